rv32_multicycle_controller: RTL
===============================

Name: rv32_multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback.
- Drives the instruction register load, the instruction decoder's latch enable, PC/register-file/memory write strobes and datapath mux selects.
- Dispatches on the decoder's registered op_type, handshakes with a single shared instruction/data memory port, and traps on illegal opcodes or memory timeouts.

Parameters:
MEM_TIMEOUT, 255, max cycles mem_req may stay unacknowledged before a bus-error trap (1..65535)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  core clock
rst  input  1  asynchronous, active-low reset (asserted = 0)
op_type  input  4  decoder op code: 0 R, 1 I, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR; 9..15 illegal
branch_taken  input  1  ALU compare result for the current branch (combinational, valid in BRANCH)
mem_ready  input  1  memory acknowledges the current request this cycle
mem_req  output  1  memory access request, held until mem_ready
mem_we  output  1  request is a write
adr_src  output  1  memory address: 0 PC, 1 alu_out register
ir_write  output  1  load IR and old_pc
decode_ena  output  1  decoder latch enable
pc_write  output  1  PC <= result bus
reg_write  output  1  register file write of result bus to rd
alu_src_a  output  2  0 PC, 1 old_pc, 2 rs1 data, 3 zero
alu_src_b  output  2  0 rs2 data, 1 imm, 2 constant 4, 3 upimm
alu_op  output  2  0 add, 1 subtract/compare, 2 funct3/funct7-decoded
result_src  output  2  0 alu_out register, 1 memory read data, 2 ALU result (combinational)
retire  output  1  one-cycle pulse on an instruction's final cycle
instret  output  CNT_W  retired-instruction count
trap  output  1  sticky; core halted
trap_cause  output  2  0 none, 1 illegal op, 2 memory timeout
state  output  4  current state (debug)

Behaviour:
- Reset (rst=0, async): state=FETCH, instret=0, trap=0, trap_cause=0, wait counter=0. All outputs are 0 while rst=0.
- Control outputs are Moore/Mealy combinational from state. Any select not listed for a state is 0.
- FETCH:
  - mem_req=1, adr_src=0, a=PC, b=4, add, result_src=2.
  - On mem_ready: ir_write=1, pc_write=1, go to DECODE. Otherwise stay.
- DECODE (1 cycle): decode_ena=1, a=old_pc, b=imm, add; branch/JAL target is latched into alu_out. Go to DISPATCH.
- DISPATCH (1 cycle, op_type now valid):
  - R goes to EXEC_R; I to EXEC_I; LOAD/STORE to MEM_ADR; BRANCH to BRANCH; LUI/AUIPC to EXEC_U; JAL to JUMP; JALR to JALR_TGT.
  - Illegal op goes to TRAP with cause 1.
- EXEC_R: a=rs1, b=rs2, op=2. Go to ALU_WB.
- EXEC_I: a=rs1, b=imm, op=2. Go to ALU_WB.
- EXEC_U: a=3 (LUI) or 1 (AUIPC), b=upimm, add. Go to ALU_WB.
- ALU_WB: reg_write=1, result_src=0, retire=1. Go to FETCH.
- MEM_ADR: a=rs1, b=imm, add. Go to MEM_READ (LOAD) or MEM_WRITE (STORE).
- MEM_READ: mem_req=1, adr_src=1. On mem_ready go to MEM_WB.
- MEM_WB: reg_write=1, result_src=1, retire=1. Go to FETCH.
- MEM_WRITE: mem_req=1, mem_we=1, adr_src=1. On mem_ready: retire=1, go to FETCH.
- BRANCH:
  - a=rs1, b=rs2, op=1, result_src=0, pc_write=branch_taken, retire=1.
  - Go to FETCH whether or not the branch is taken.
- JALR_TGT: a=rs1, b=imm, add; target is latched into alu_out. Go to JUMP.
- JUMP: pc_write=1, result_src=0 (target); a=old_pc, b=4, add (link value into alu_out). Go to ALU_WB.
- Memory wait timeout:
  - The counter clears on entry to any mem_req state and increments each cycle mem_req=1 && !mem_ready.
  - When it reaches MEM_TIMEOUT without ack: go to TRAP, cause 2, mem_req drops.
  - mem_ready arriving on the same cycle the count hits MEM_TIMEOUT: ack wins.
- TRAP: all strobes 0, trap=1, no exit except reset.
- Cycle counts per instruction (zero memory wait):
  - R, I, U: 5 cycles.
  - Load: 6. Store: 5. Branch: 4.
  - JAL: 5. JALR: 6.
  - Each extra mem wait cycle adds 1.
- instret:
  - Increments on each cycle retire=1.
  - Wraps modulo 2^CNT_W.
  - Updates and retire pulse are registered-state based, not glitching.
- Reset asserted mid-instruction: immediate return to reset values; a pending memory request is abandoned, and no write strobe is asserted during reset.

Test Plan:
- ADD (op 0), mem_ready always 1 -> states FETCH, DECODE, DISPATCH, EXEC_R, ALU_WB; reg_write=1 only in cycle 5; instret 0→1.
- LW (op 2), mem_ready delayed 3 cycles in MEM_READ -> mem_req held with adr_src=1 for 4 cycles; MEM_WB has result_src=1 and reg_write; total 9 cycles.
- BEQ (op 4) with branch_taken=0 then =1 -> pc_write=0 then 1 in BRANCH; both retire in 4 cycles; instret +2.
- JALR (op 8) -> JALR_TGT has a=2, b=1; JUMP has pc_write=1, a=1, b=2; ALU_WB has reg_write=1; 6 cycles.
- op_type=12 -> TRAP after DISPATCH, trap_cause=1; mem_req stays 0 for 20 further cycles; rst pulse low restores FETCH with instret=0.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP with cause 2 after 4 wait cycles. Repeat with mem_ready on the 4th wait cycle -> DECODE instead, no trap.

Source files
------------

// File: rtl/rv32_multicycle_controller.sv
// rtl/rv32_multicycle_controller.sv - main control FSM of the multicycle RV32I core
// Sequences fetch/decode/execute/memory/writeback and traps on illegal ops or memory timeouts.
module rv32_multicycle_controller #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       op_type,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             adr_src,
   output logic             ir_write,
   output logic             decode_ena,
   output logic             pc_write,
   output logic             reg_write,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       result_src,
   output logic             retire,
   output logic [CNT_W-1:0] instret,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [3:0]       state
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_DISPATCH  = 4'd2,
      S_EXEC_R    = 4'd3,
      S_EXEC_I    = 4'd4,
      S_EXEC_U    = 4'd5,
      S_ALU_WB    = 4'd6,
      S_MEM_ADR   = 4'd7,
      S_MEM_READ  = 4'd8,
      S_MEM_WB    = 4'd9,
      S_MEM_WRITE = 4'd10,
      S_BRANCH    = 4'd11,
      S_JALR_TGT  = 4'd12,
      S_JUMP      = 4'd13,
      S_TRAP      = 4'd14
   } state_t;

   localparam logic [15:0] LP_LAST_WAIT = 16'(MEM_TIMEOUT - 1);

   state_t           r_state, w_next;
   logic [15:0]      r_wait;
   logic [1:0]       r_cause, w_cause_next;
   logic [CNT_W-1:0] r_instret;
   logic             w_timeout;
   logic             w_mem_req, w_mem_we, w_adr_src, w_ir_write, w_decode_ena;
   logic             w_pc_write, w_reg_write, w_retire;
   logic [1:0]       w_alu_src_a, w_alu_src_b, w_alu_op, w_result_src;

   // Last allowed wait cycle: an unacknowledged request here ends in a bus-error trap.
   assign w_timeout = (r_wait == LP_LAST_WAIT);

   always_comb begin
      w_next       = r_state;
      w_cause_next = r_cause;
      w_mem_req    = 1'b0;
      w_mem_we     = 1'b0;
      w_adr_src    = 1'b0;
      w_ir_write   = 1'b0;
      w_decode_ena = 1'b0;
      w_pc_write   = 1'b0;
      w_reg_write  = 1'b0;
      w_retire     = 1'b0;
      w_alu_src_a  = 2'd0;
      w_alu_src_b  = 2'd0;
      w_alu_op     = 2'd0;
      w_result_src = 2'd0;
      case (r_state)
         S_FETCH: begin
            w_mem_req    = 1'b1;
            w_alu_src_b  = 2'd2;
            w_result_src = 2'd2;
            if (mem_ready) begin
               w_ir_write = 1'b1;
               w_pc_write = 1'b1;
               w_next     = S_DECODE;
            end else if (w_timeout) begin
               w_next       = S_TRAP;
               w_cause_next = 2'd2;
            end
         end
         S_DECODE: begin
            w_decode_ena = 1'b1;
            w_alu_src_a  = 2'd1;
            w_alu_src_b  = 2'd1;
            w_next       = S_DISPATCH;
         end
         S_DISPATCH: begin
            case (op_type)
               4'd0:      w_next = S_EXEC_R;
               4'd1:      w_next = S_EXEC_I;
               4'd2, 4'd3: w_next = S_MEM_ADR;
               4'd4:      w_next = S_BRANCH;
               4'd5, 4'd6: w_next = S_EXEC_U;
               4'd7:      w_next = S_JUMP;
               4'd8:      w_next = S_JALR_TGT;
               default: begin
                  w_next       = S_TRAP;
                  w_cause_next = 2'd1;
               end
            endcase
         end
         S_EXEC_R: begin
            w_alu_src_a = 2'd2;
            w_alu_op    = 2'd2;
            w_next      = S_ALU_WB;
         end
         S_EXEC_I: begin
            w_alu_src_a = 2'd2;
            w_alu_src_b = 2'd1;
            w_alu_op    = 2'd2;
            w_next      = S_ALU_WB;
         end
         S_EXEC_U: begin
            w_alu_src_a = (op_type == 4'd5) ? 2'd3 : 2'd1;
            w_alu_src_b = 2'd3;
            w_next      = S_ALU_WB;
         end
         S_ALU_WB: begin
            w_reg_write = 1'b1;
            w_retire    = 1'b1;
            w_next      = S_FETCH;
         end
         S_MEM_ADR: begin
            w_alu_src_a = 2'd2;
            w_alu_src_b = 2'd1;
            w_next      = (op_type == 4'd2) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            w_mem_req = 1'b1;
            w_adr_src = 1'b1;
            if (mem_ready) begin
               w_next = S_MEM_WB;
            end else if (w_timeout) begin
               w_next       = S_TRAP;
               w_cause_next = 2'd2;
            end
         end
         S_MEM_WB: begin
            w_reg_write  = 1'b1;
            w_result_src = 2'd1;
            w_retire     = 1'b1;
            w_next       = S_FETCH;
         end
         S_MEM_WRITE: begin
            w_mem_req = 1'b1;
            w_mem_we  = 1'b1;
            w_adr_src = 1'b1;
            if (mem_ready) begin
               w_retire = 1'b1;
               w_next   = S_FETCH;
            end else if (w_timeout) begin
               w_next       = S_TRAP;
               w_cause_next = 2'd2;
            end
         end
         S_BRANCH: begin
            w_alu_src_a = 2'd2;
            w_alu_op    = 2'd1;
            w_pc_write  = branch_taken;
            w_retire    = 1'b1;
            w_next      = S_FETCH;
         end
         S_JALR_TGT: begin
            w_alu_src_a = 2'd2;
            w_alu_src_b = 2'd1;
            w_next      = S_JUMP;
         end
         S_JUMP: begin
            // PC takes the latched target while the ALU forms the link value.
            w_pc_write  = 1'b1;
            w_alu_src_a = 2'd1;
            w_alu_src_b = 2'd2;
            w_next      = S_ALU_WB;
         end
         default: w_next = S_TRAP;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_FETCH;
         r_wait    <= 16'd0;
         r_cause   <= 2'd0;
         r_instret <= '0;
      end else begin
         r_state <= w_next;
         r_cause <= w_cause_next;
         if (w_next != r_state)
            r_wait <= 16'd0;
         else if (w_mem_req && !mem_ready)
            r_wait <= r_wait + 16'd1;
         if (w_retire)
            r_instret <= r_instret + 1'b1;
      end
   end

   // Combinational strobes are forced low while reset is held.
   assign mem_req    = rst & w_mem_req;
   assign mem_we     = rst & w_mem_we;
   assign adr_src    = rst & w_adr_src;
   assign ir_write   = rst & w_ir_write;
   assign decode_ena = rst & w_decode_ena;
   assign pc_write   = rst & w_pc_write;
   assign reg_write  = rst & w_reg_write;
   assign retire     = rst & w_retire;
   assign alu_src_a  = rst ? w_alu_src_a  : 2'd0;
   assign alu_src_b  = rst ? w_alu_src_b  : 2'd0;
   assign alu_op     = rst ? w_alu_op     : 2'd0;
   assign result_src = rst ? w_result_src : 2'd0;
   assign instret    = r_instret;
   assign trap       = rst & (r_state == S_TRAP);
   assign trap_cause = r_cause;
   assign state      = r_state;

endmodule
